// File: rtl/my_clock_pkg.sv
// Shared types and parameter defaults for the multi-channel clock generator.
package my_clock_pkg;

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        RESET    = 3'd1,
        RUN      = 3'd2,
        RECFG    = 3'd3,
        STOPPING = 3'd4
    } ch_state_e;

    localparam int NUM_CH_DEF   = 4;
    localparam int DIV_W_DEF    = 8;
    localparam int RST_HOLD_DEF = 4;
    localparam int HOLD_W       = 8;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/my_clk_div_ch.sv
// One divided-clock channel: period counter, sequencing FSM and pending divisor.
//
// state    | meaning
// OFF      | stopped, clk_out low, reset asserted
// RESET    | clock running, reset held for RST_HOLD output periods
// RUN      | clock running, reset released, locked
// RECFG    | old divisor runs to its wrap, then new divisor applied
// STOPPING | current period completes, then OFF
module my_clk_div_ch
    import my_clock_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int RST_HOLD = RST_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             req_en,
    input  logic [DIV_W-1:0] req_div,
    output logic             busy,
    output logic             clk_out,
    output logic             rst_out,
    output logic             locked
);

    ch_state_e          state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   pend_q, pend_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               clk_q, clk_d;
    logic               rst_out_q, rst_out_d;
    logic               lock_q, lock_d;
    logic               wrap;

    // div_q is at least 2 whenever wrap is used, so the subtraction cannot underflow.
    assign wrap = (cnt_q == (div_q - DIV_W'(1)));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        cnt_d   = wrap ? '0 : cnt_q + DIV_W'(1);

        case (state_q)
            OFF: begin
                cnt_d = '0;
                if (req && req_en) begin
                    div_d   = req_div;
                    hold_d  = HOLD_W'(RST_HOLD);
                    state_d = RESET;
                end
            end
            RESET, RUN: begin
                if (req) begin
                    if (req_en) begin
                        pend_d  = req_div;
                        state_d = RECFG;
                    end else begin
                        state_d = STOPPING;
                    end
                end else if (state_q == RESET && wrap) begin
                    if (hold_q == HOLD_W'(1)) begin
                        state_d = RUN;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
            end
            RECFG: begin
                if (wrap) begin
                    div_d   = pend_q;
                    hold_d  = HOLD_W'(RST_HOLD);
                    state_d = RESET;
                end
            end
            STOPPING: begin
                if (wrap) begin
                    state_d = OFF;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = OFF;
            end
        endcase

        // Output registers follow the next state so clk_out rises with the first count.
        clk_d = (state_d != OFF) && (cnt_d < (div_d >> 1));

        rst_out_d = rst_out_q;
        if (state_d == OFF || state_d == RESET) begin
            rst_out_d = 1'b1;
        end else if (state_d == RUN) begin
            rst_out_d = 1'b0;
        end

        lock_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            div_q     <= '0;
            pend_q    <= '0;
            hold_q    <= '0;
            clk_q     <= 1'b0;
            rst_out_q <= 1'b1;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            hold_q    <= hold_d;
            clk_q     <= clk_d;
            rst_out_q <= rst_out_d;
            lock_q    <= lock_d;
        end
    end

    assign busy    = (state_q == RECFG) || (state_q == STOPPING);
    assign clk_out = clk_q;
    assign rst_out = rst_out_q;
    assign locked  = lock_q;

endmodule

// File: rtl/my_multi_clock_gen.sv
// Multi-channel clock generator: decodes configuration requests onto
// NUM_CH independent divider channels.
module my_multi_clock_gen
    import my_clock_pkg::*;
#(
    parameter  int NUM_CH   = NUM_CH_DEF,
    parameter  int DIV_W    = DIV_W_DEF,
    parameter  int RST_HOLD = RST_HOLD_DEF,
    localparam int CH_W     = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_en,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rst_out,
    output logic [NUM_CH-1:0] locked
);

    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH-1:0] ch_req;
    logic              busy_sel;
    logic              ch_ok;
    logic              illegal;
    logic              accept;
    logic              cfg_err_q, cfg_err_d;

    // An out-of-range channel is never busy, so the request is taken and flagged.
    always_comb begin
        busy_sel = 1'b0;
        ch_ok    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                ch_ok    = 1'b1;
                busy_sel = ch_busy[i];
            end
        end
    end

    assign cfg_ready = ~rst & ~busy_sel;
    assign accept    = cfg_valid & cfg_ready;
    assign illegal   = ~ch_ok | (cfg_en & (cfg_div < DIV_W'(2)));
    assign cfg_err_d = accept & illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_req[g] = accept & ~illegal & (cfg_ch == CH_W'(g));

        my_clk_div_ch #(
            .DIV_W    (DIV_W),
            .RST_HOLD (RST_HOLD)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .req     (ch_req[g]),
            .req_en  (cfg_en),
            .req_div (cfg_div),
            .busy    (ch_busy[g]),
            .clk_out (clk_out[g]),
            .rst_out (rst_out[g]),
            .locked  (locked[g])
        );
    end

endmodule

// File: tb/tb_my_multi_clock_gen.sv
// Directed bench for my_multi_clock_gen with three channels (so cfg_ch=3 is out of range).
module tb_my_multi_clock_gen;

    localparam int NUM_CH   = 3;
    localparam int DIV_W    = 8;
    localparam int RST_HOLD = 4;

    logic              clk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic              cfg_en;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] rst_out;
    logic [NUM_CH-1:0] locked;

    int n_chk;
    int n_fail;
    int cyc;
    int s0, s1, s2, a, w, c;

    logic [7:0]  wave8;
    logic [9:0]  w1, w0, e0;
    logic [11:0] wave12;
    logic [3:0]  wave4;
    logic        acc;

    my_multi_clock_gen #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .rst_out   (rst_out),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic send(input logic [1:0] ch, input logic en, input logic [DIV_W-1:0] div);
        cfg_ch    = ch;
        cfg_en    = en;
        cfg_div   = div;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Expected divided clock c cycles into a channel started (cnt=0) at cycle s.
    function automatic logic exp_clk(input int cc, input int s, input int d);
        return ((cc - s) % d) < (d / 2);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; cfg_valid = 1'b0; cfg_en = 1'b0; cfg_ch = '0; cfg_div = '0;
        tick(); tick();
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_rst_out", 32'(rst_out), 32'h7);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);

        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(cfg_ready), 32'd1);
        chk("idle_off", 32'({clk_out, rst_out, locked}), 32'({3'b000, 3'b111, 3'b000}));

        // ch0 div 4: first high right after acceptance, reset release 17 cycles after accept
        send(2'd0, 1'b1, 8'd4);
        s0 = cyc;
        wave8 = '0;
        for (int t = 0; t < 8; t++) begin
            wave8 = {wave8[6:0], clk_out[0]};
            tick();
        end
        chk("ch0_wave", 32'(wave8), 32'hCC);
        go_to(s0 + 15);
        chk("ch0_pre_lock", 32'({rst_out[0], locked[0]}), 32'b10);
        tick();
        chk("ch0_lock", 32'({rst_out[0], locked[0]}), 32'b01);

        // ch1 div 5: 2 high, 3 low; ch0 keeps its phase
        cfg_ch = 2'd1;
        #1;
        chk("ch1_ready", 32'(cfg_ready), 32'd1);
        send(2'd1, 1'b1, 8'd5);
        s1 = cyc;
        w1 = '0; w0 = '0; e0 = '0;
        for (int t = 0; t < 10; t++) begin
            w1 = {w1[8:0], clk_out[1]};
            w0 = {w0[8:0], clk_out[0]};
            e0 = {e0[8:0], exp_clk(cyc, s0, 4)};
            tick();
        end
        chk("ch1_wave", 32'(w1), 32'(10'b1100011000));
        chk("ch0_undisturbed", 32'(w0), 32'(e0));
        go_to(s1 + 19);
        chk("ch1_pre_lock", 32'(locked), 32'b001);
        tick();
        chk("ch1_lock", 32'(locked), 32'b011);
        chk("ch1_rst_out", 32'(rst_out), 32'b100);

        // illegal requests
        send(2'd2, 1'b1, 8'd1);
        chk("err_div1", 32'(cfg_err), 32'd1);
        chk("err_div1_state", 32'({rst_out, locked, clk_out[2]}), 32'({3'b100, 3'b011, 1'b0}));
        tick();
        chk("err_div1_clear", 32'(cfg_err), 32'd0);
        send(2'd3, 1'b1, 8'd4);
        chk("err_ch", 32'(cfg_err), 32'd1);
        chk("err_ch_state", 32'({rst_out, locked, clk_out[2]}), 32'({3'b100, 3'b011, 1'b0}));
        tick();
        chk("err_ch_clear", 32'(cfg_err), 32'd0);
        chk("err_ch0_phase", 32'(clk_out[0]), 32'(exp_clk(cyc, s0, 4)));
        send(2'd2, 1'b0, 8'd9);
        chk("stop_off_noerr", 32'({cfg_err, clk_out[2], rst_out[2], locked[2]}), 32'b0010);

        // ch0 reconfiguration 4 -> 6
        send(2'd0, 1'b1, 8'd6);
        a = cyc;
        w = a + 4 - ((a - s0) % 4);
        chk("recfg_unlock", 32'(locked), 32'b010);
        chk("recfg_busy", 32'(cfg_ready), 32'd0);
        go_to(w - 1);
        chk("recfg_busy_end", 32'(cfg_ready), 32'd0);
        tick();
        chk("recfg_ready", 32'(cfg_ready), 32'd1);
        chk("recfg_rst_out", 32'(rst_out[0]), 32'd1);
        s0 = w;
        wave12 = '0;
        for (int t = 0; t < 12; t++) begin
            wave12 = {wave12[10:0], clk_out[0]};
            tick();
        end
        chk("recfg_wave", 32'(wave12), 32'(12'b111000111000));
        go_to(w + 23);
        chk("recfg_pre_lock", 32'(locked[0]), 32'd0);
        tick();
        chk("recfg_lock", 32'({rst_out[0], locked[0]}), 32'b01);

        // stop ch2 (div 6) while its output is high
        send(2'd2, 1'b1, 8'd6);
        s2 = cyc;
        go_to(s2 + 24);
        chk("ch2_lock", 32'(locked[2]), 32'd1);
        go_to(s2 + 25);
        send(2'd2, 1'b0, 8'd0);
        a = cyc;
        chk("stop_unlock", 32'({locked[2], cfg_ready}), 32'b00);
        wave4 = '0;
        for (int t = 0; t < 4; t++) begin
            wave4 = {wave4[2:0], clk_out[2]};
            tick();
        end
        chk("stop_tail", 32'(wave4), 32'b1000);
        chk("stop_off", 32'({clk_out[2], rst_out[2], locked[2], cfg_ready}), 32'b0101);
        acc = 1'b0;
        for (int t = 0; t < 12; t++) begin
            acc = acc | clk_out[2];
            tick();
        end
        chk("stop_quiet", 32'(acc), 32'd0);

        // asynchronous reset while ch0 and ch1 run
        c = cyc + ((6 - ((cyc - s0) % 6)) % 6);
        go_to(c);
        chk("pre_rst", 32'({locked, clk_out[0]}), 32'({3'b011, 1'b1}));
        #2;
        rst = 1'b1;
        #1;
        chk("async_clk_out", 32'(clk_out), 32'd0);
        chk("async_rst_out", 32'(rst_out), 32'h7);
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_ready", 32'(cfg_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_off", 32'({clk_out, rst_out, locked, cfg_err}), 32'({3'b000, 3'b111, 3'b000, 1'b0}));
        chk("post_rst_ready", 32'(cfg_ready), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/my_multi_clock_gen.md
MY_MULTI_CLOCK_GEN -- requirements
Module: my_multi_clock_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent output clock channels (1..16).
REQ-002 The block SHALL have parameter DIV_W, default 8, giving the divisor width.
REQ-003 The block SHALL have parameter RST_HOLD, default 4, giving the number of full output periods that channel reset is held after enable or re-configuration (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: source clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: configuration request.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: request accepted when cfg_valid and cfg_ready are both high on a clk edge.
REQ-008 The block SHALL have port cfg_ch, input, $clog2(NUM_CH) bits (minimum 1): target channel.
REQ-009 The block SHALL have port cfg_en, input, 1 bit: 1 = run the channel at cfg_div, 0 = stop the channel.
REQ-010 The block SHALL have port cfg_div, input, DIV_W bits: divisor; the output period is cfg_div source cycles.
REQ-011 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an accepted request is illegal.
REQ-012 The block SHALL have port clk_out, output, NUM_CH bits: divided clocks, one register per channel.
REQ-013 The block SHALL have port rst_out, output, NUM_CH bits: per-channel active-high reset.
REQ-014 The block SHALL have port locked, output, NUM_CH bits: channel running at its configured divisor with reset released.

Function
REQ-015 Each channel SHALL contain a counter cnt running 0..div-1, and SHALL drive registered clk_out = (cnt < div>>1) while not OFF; for odd div the output is high floor(div/2) cycles and low for the remaining cycles.
REQ-016 Each channel SHALL have exactly these states: OFF, RESET, RUN, RECFG, STOPPING.
REQ-017 In OFF, a channel SHALL drive clk_out=0, rst_out=1, locked=0, with cnt held at 0.
REQ-018 An accepted request with cfg_en=1 to an OFF channel SHALL load div, SHALL go to RESET on the next edge with cnt=0, and clk_out SHALL rise 1 cycle after acceptance.
REQ-019 In RESET, the channel SHALL keep rst_out=1; after RST_HOLD counter wraps it SHALL go to RUN with rst_out=0 and locked=1 on the same edge, i.e. accept+1+RST_HOLD*div cycles.
REQ-020 An accepted request with cfg_en=1 to a RESET or RUN channel SHALL store the pending div, go to RECFG and set locked=0 next cycle, and keep the old div running.
REQ-021 At the next wrap (cnt==div-1), RECFG SHALL apply the pending div, set cnt=0, assert rst_out=1 and go to RESET, so that no output pulse is shortened.
REQ-022 An accepted request with cfg_en=0 SHALL go to STOPPING with locked=0, and SHALL go to OFF at the next wrap.
REQ-023 A request with cfg_en=0 to an OFF channel SHALL be accepted with no effect.
REQ-024 cfg_ready SHALL be 0 while rst is high, and SHALL be 0 when the channel addressed by cfg_ch is in RECFG or STOPPING; otherwise it SHALL be 1.
REQ-025 cfg_ready SHALL be combinational from cfg_ch and channel state.
REQ-026 The following SHALL be illegal and accepted with cfg_err pulsed next cycle and no state change: cfg_div < 2 with cfg_en=1, or cfg_ch >= NUM_CH.
REQ-027 Channels SHALL be fully independent; one request per cycle at most.
REQ-028 cfg_div SHALL be treated as unsigned; cfg_div = 2^DIV_W-1 SHALL be legal.
REQ-029 The counter compare SHALL use DIV_W-bit arithmetic without overflow.

Reset
REQ-030 While rst is high, all channels SHALL be OFF, cnt=0, clk_out=0, rst_out all 1, locked=0, cfg_err=0, pending cleared.
REQ-031 Assertion of rst mid-operation SHALL apply the values of REQ-030 immediately (asynchronous).
REQ-032 Release of rst SHALL leave channels OFF until configured.

Structure
REQ-033 Package my_clock_pkg SHALL hold the channel state enum (OFF, RESET, RUN, RECFG, STOPPING) and the parameter defaults.
REQ-034 Sub-module my_clk_div_ch SHALL implement one channel (counter, FSM, pending div); the top SHALL instantiate NUM_CH copies with a generate loop and decode cfg.

Verification
REQ-035 With RST_HOLD=4, a request to ch0 with en=1, div=4: clk_out[0] rises accept+1, period is 4 cycles with 2 high, and rst_out[0]/locked[0] change at accept+17.
REQ-036 A request to ch1 with div=5: the high phase is 2 cycles and the low phase is 3 cycles; ch0 is undisturbed.
REQ-037 A request to RUN ch0 changing div 4->6: locked[0] drops next cycle, cfg_ready is 0 for ch0 until the wrap, the first 6-cycle period starts immediately after the wrap, and locked[0] reasserts 24 cycles later.
REQ-038 A request with div=1, and a request with cfg_ch=NUM_CH: cfg_err pulses one cycle each time, and all outputs are unchanged.
REQ-039 A request with en=0 to RUN ch2 mid-high-phase: the pulse completes, the channel goes to OFF at the wrap, and clk_out[2] stays 0.
REQ-040 rst asserted while two channels are RUN: all clk_out go 0, rst_out go 1 and locked go 0 without waiting for a clk edge.
